// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with elaboration-time KMP fallback table.
// Define SEQDET_COUNT_EN to add the saturating match_cnt output and its counter.
module seq_detect_param #(
   parameter int           N       = 8,
   parameter logic [N-1:0] PATTERN = 8'b01000101,
   parameter int           OVERLAP = 1,
   parameter int           CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     clear,
   output logic                     match,
   output logic [$clog2(N+1)-1:0]   prefix_len
`ifdef SEQDET_COUNT_EN
   ,
   output logic [CNT_W-1:0]         match_cnt
`endif
);
   localparam int PW   = $clog2(N+1);
   localparam int ROWS = 2**PW;

   if (N < 2 || N > 16) begin : g_bad_n
      $error("seq_detect_param: N must be in 2..16");
   end
   if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W must be in 1..16");
   end

   // Longest pattern prefix that is a suffix of (first p pattern bits, then b).
   function automatic int kmp_step(int p, int b);
      int   res;
      logic ok;
      logic sb;
      res = 0;
      if (p < N) begin
         for (int k = 1; k <= p + 1; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
               sb = (p + 1 - k + i == p) ? (b != 0) : PATTERN[N-1-(p+1-k+i)];
               if (PATTERN[N-1-i] != sb) ok = 1'b0;
            end
            if (ok) res = k;
         end
      end
      return res;
   endfunction

   function automatic int border_len();
      int   res;
      logic ok;
      res = 0;
      for (int k = 1; k < N; k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            if (PATTERN[N-1-i] != PATTERN[k-1-i]) ok = 1'b0;
         end
         if (ok) res = k;
      end
      return res;
   endfunction

   localparam int BORDER = border_len();

   logic [PW-1:0] nxt_tbl [ROWS][2];
   logic          hit_tbl [ROWS][2];

   for (genvar g = 0; g < ROWS; g++) begin : g_row
      for (genvar b = 0; b < 2; b++) begin : g_bit
         localparam int K  = kmp_step(g, b);
         localparam int NX = (K == N) ? ((OVERLAP != 0) ? BORDER : 0) : K;
         assign nxt_tbl[g][b] = PW'(NX);
         assign hit_tbl[g][b] = (K == N);
      end
   end

   logic [PW-1:0] p_q;
   logic [PW-1:0] p_nxt;
   logic          match_q;
   logic          hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q     <= '0;
         match_q <= 1'b0;
      end else begin
         p_q     <= p_nxt;
         match_q <= hit;
      end
   end

   // clear overrides any accepted bit, including one that would complete the pattern
   always_comb begin
      p_nxt = p_q;
      hit   = 1'b0;
      if (bit_valid) begin
         p_nxt = nxt_tbl[p_q][bit_in];
         hit   = hit_tbl[p_q][bit_in];
      end
      if (clear) begin
         p_nxt = '0;
         hit   = 1'b0;
      end
   end

   always_comb begin
      prefix_len = p_q;
      match      = match_q;
   end

`ifdef SEQDET_COUNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) cnt_q <= '0;
      else if (hit)     cnt_q <= sat_inc(cnt_q);
   end

   always_comb match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and random checks of seq_detect_param against a string-matching model.
// Counter checks are active when SEQDET_COUNT_EN is defined.
module tb_seq_detect_param;
   localparam int         N   = 8;
   localparam logic [7:0] PAT = 8'b01000101;
`ifdef SEQDET_COUNT_EN
   localparam int OW = 33;
`else
   localparam int OW = 15;
`endif

   logic clk = 1'b0;
   logic rst, bit_in, bit_valid, clear;
   logic m_ov, m_nov, m_c2;
   logic [3:0] p_ov, p_nov, p_c2;
`ifdef SEQDET_COUNT_EN
   logic [7:0] c_ov, c_nov;
   logic [1:0] c_c2;
`endif

   int checks   = 0;
   int failures = 0;

   // model: index 0 = overlapping, 1 = non-overlapping, 2 = overlapping with 2-bit counter
   logic [31:0] hist [3];
   int          hlen [3];
   logic        em   [3];
   int          cnt  [3];
   int          smax [3] = '{255, 255, 3};
   int          ovl  [3] = '{1, 0, 1};

   always #5 clk = ~clk;

   seq_detect_param #(.N(8), .PATTERN(8'b01000101), .OVERLAP(1), .CNT_W(8)) u_ov (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
      .match(m_ov), .prefix_len(p_ov)
`ifdef SEQDET_COUNT_EN
      , .match_cnt(c_ov)
`endif
   );
   seq_detect_param #(.N(8), .PATTERN(8'b01000101), .OVERLAP(0), .CNT_W(8)) u_nov (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
      .match(m_nov), .prefix_len(p_nov)
`ifdef SEQDET_COUNT_EN
      , .match_cnt(c_nov)
`endif
   );
   seq_detect_param #(.N(8), .PATTERN(8'b01000101), .OVERLAP(1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
      .match(m_c2), .prefix_len(p_c2)
`ifdef SEQDET_COUNT_EN
      , .match_cnt(c_c2)
`endif
   );

   // longest k < N where the last k accepted bits equal the first k pattern bits
   function automatic int best(logic [31:0] h, int len);
      int r;
      r = 0;
      for (int k = 1; k < N; k++)
         if (k <= len && ((h & ((32'd1 << k) - 1)) == (32'(PAT) >> (N - k)))) r = k;
      return r;
   endfunction

   function automatic logic [OW-1:0] expv();
      return {em[0], 4'(best(hist[0], hlen[0])), em[1], 4'(best(hist[1], hlen[1])),
              em[2], 4'(best(hist[2], hlen[2]))
`ifdef SEQDET_COUNT_EN
              , 8'(cnt[0]), 8'(cnt[1]), 2'(cnt[2])
`endif
             };
   endfunction

   function automatic logic [OW-1:0] obs();
      return {m_ov, p_ov, m_nov, p_nov, m_c2, p_c2
`ifdef SEQDET_COUNT_EN
              , c_ov, c_nov, c_c2
`endif
             };
   endfunction

   task automatic drive(input logic r, input logic b, input logic v, input logic c);
      @(negedge clk);
      rst = r; bit_in = b; bit_valid = v; clear = c;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         em[i] = 1'b0;
         if (r || c) begin
            hist[i] = '0; hlen[i] = 0; cnt[i] = 0;
         end else if (v) begin
            hist[i] = (hist[i] << 1) | 32'(b);
            if (hlen[i] < 16) hlen[i]++;
            if (hlen[i] >= N && hist[i][7:0] == PAT) begin
               em[i] = 1'b1;
               if (cnt[i] < smax[i]) cnt[i]++;
               if (ovl[i] == 0) begin hist[i] = '0; hlen[i] = 0; end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs() !== expv()) begin
         failures++; $display("FAIL reset_model obs=%h exp=%h", obs(), expv());
      end
      checks++;
      if (m_ov !== 1'b0 || p_ov !== 4'd0 || m_nov !== 1'b0 || p_c2 !== 4'd0) begin
         failures++; $display("FAIL reset_state match=%b prefix=%0d want 0/0", m_ov, p_ov);
      end
   endtask

   task automatic test_basic();
      logic [7:0] s;
      s = PAT;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         drive(1'b0, s[i], 1'b1, 1'b0);
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL basic bit%0d obs=%h exp=%h", 7 - i, obs(), expv());
         end
      end
      checks++;
      if (m_ov !== 1'b1 || p_ov !== 4'd2) begin
         failures++; $display("FAIL basic_match match=%b prefix=%0d want 1/2", m_ov, p_ov);
      end
`ifdef SEQDET_COUNT_EN
      checks++;
      if (c_ov !== 8'd1) begin
         failures++; $display("FAIL basic_cnt got=%0d want=1", c_ov);
      end
`endif
   endtask

   task automatic test_overlap();
      logic [13:0] s;
      int pc_ov, pc_nov;
      s = 14'b01000101000101;
      pc_ov = 0; pc_nov = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 13; i >= 0; i--) begin
         drive(1'b0, s[i], 1'b1, 1'b0);
         if (m_ov)  pc_ov++;
         if (m_nov) pc_nov++;
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL overlap bit%0d obs=%h exp=%h", 13 - i, obs(), expv());
         end
      end
      checks++;
      if (pc_ov != 2 || pc_nov != 1) begin
         failures++; $display("FAIL overlap_pulses ov=%0d nov=%0d want 2/1", pc_ov, pc_nov);
      end
`ifdef SEQDET_COUNT_EN
      checks++;
      if (c_ov !== 8'd2 || c_nov !== 8'd1) begin
         failures++; $display("FAIL overlap_cnt ov=%0d nov=%0d want 2/1", c_ov, c_nov);
      end
`endif
   endtask

   task automatic test_gap();
      logic [7:0] s;
      s = PAT;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 4; i--) drive(1'b0, s[i], 1'b1, 1'b0);
      for (int g = 0; g < 5; g++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         checks++;
         if (p_ov !== 4'd4 || m_ov !== 1'b0 || obs() !== expv()) begin
            failures++; $display("FAIL gap cyc%0d prefix=%0d match=%b want 4/0", g, p_ov, m_ov);
         end
      end
      for (int i = 3; i >= 0; i--) drive(1'b0, s[i], 1'b1, 1'b0);
      checks++;
      if (m_ov !== 1'b1 || obs() !== expv()) begin
         failures++; $display("FAIL gap_match match=%b want 1 obs=%h exp=%h", m_ov, obs(), expv());
      end
   endtask

   task automatic test_rst_mid();
      logic [7:0] s;
      s = PAT;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 7; i >= 1; i--) drive(1'b0, s[i], 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (p_ov !== 4'd0 || m_ov !== 1'b0) begin
         failures++; $display("FAIL rst_mid prefix=%0d match=%b want 0/0", p_ov, m_ov);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (m_ov !== 1'b0 || obs() !== expv()) begin
         failures++; $display("FAIL rst_mid_one obs=%h exp=%h", obs(), expv());
      end
      for (int i = 7; i >= 0; i--) drive(1'b0, s[i], 1'b1, 1'b0);
      checks++;
      if (m_ov !== 1'b1 || obs() !== expv()) begin
         failures++; $display("FAIL rst_mid_match match=%b want 1 obs=%h exp=%h", m_ov, obs(), expv());
      end
   endtask

   task automatic test_saturate_clear();
      logic [7:0] s;
      int want [5] = '{1, 2, 3, 3, 3};
      s = PAT;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 5; p++) begin
         for (int i = 7; i >= 0; i--) drive(1'b0, s[i], 1'b1, 1'b0);
         checks++;
         if (m_c2 !== 1'b1 || obs() !== expv()) begin
            failures++; $display("FAIL sat_pat%0d obs=%h exp=%h", p, obs(), expv());
         end
`ifdef SEQDET_COUNT_EN
         checks++;
         if (c_c2 !== 2'(want[p])) begin
            failures++; $display("FAIL sat_cnt%0d got=%0d want=%0d", p, c_c2, want[p]);
         end
`endif
      end
      for (int i = 7; i >= 1; i--) drive(1'b0, s[i], 1'b1, 1'b0);
      drive(1'b0, s[0], 1'b1, 1'b1);
      checks++;
      if (m_c2 !== 1'b0 || p_c2 !== 4'd0 || m_ov !== 1'b0 || obs() !== expv()) begin
         failures++; $display("FAIL clear_last match=%b prefix=%0d want 0/0", m_c2, p_c2);
      end
`ifdef SEQDET_COUNT_EN
      checks++;
      if (c_c2 !== 2'd0 || c_ov !== 8'd0) begin
         failures++; $display("FAIL clear_cnt c2=%0d ov=%0d want 0/0", c_c2, c_ov);
      end
`endif
   endtask

   task automatic test_random();
      logic [7:0] s;
      s = PAT;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 7; i >= 0; i--) begin
               drive(1'b0, s[i], 1'b1, 1'b0);
               checks++;
               if (obs() !== expv()) begin
                  failures++; $display("FAIL random_pat n%0d obs=%h exp=%h", n, obs(), expv());
               end
            end
         end else begin
            drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 49) == 0));
            checks++;
            if (obs() !== expv()) begin
               failures++; $display("FAIL random n%0d obs=%h exp=%h", n, obs(), expv());
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         hist[i] = '0; hlen[i] = 0; em[i] = 1'b0; cnt[i] = 0;
      end
      test_reset();
      test_basic();
      test_overlap();
      test_gap();
      test_rst_mid();
      test_saturate_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
